// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave register sequencer.
// Pure declarations: no latency or flow control of its own.
// Consumers import with i2c_slave_pkg::*.
package i2c_slave_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   // Bus-level value of the acknowledge bit.
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   // Direction bit carried in the LSB of the address byte.
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic [6:0] SLAVE_ADDR_DEF = 7'h53;

endpackage

// File: rtl/i2c_slave_reg_sequencer_sync_edge.sv
// Synchronizes raw SCL/SDA into clk and derives SCL edges plus START/STOP pulses.
// Latency: SYNC_STAGES cycles from pad to synchronized level, edge pulses on the same cycle.
// No backpressure: free-running, every pulse lasts exactly one cycle.
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic async_rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;

   // Synchronizer chains plus one-cycle history; idle bus level (1) on reset.
   always_ff @(posedge clk or negedge async_rst) begin
      if (!async_rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // SDA may only change with SCL high when the master signals START or STOP.
   assign scl_rise  =  scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s &  scl_prev_q;
   assign start_det =  scl_s &  sda_prev_q & ~sda_s;
   assign stop_det  =  scl_s & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_reg_sequencer.sv
// I2C slave: address match, register pointer, auto-incrementing writes/reads to a reg port.
// Latency: reg_we one cycle after the 8th data rise; reg_re one cycle after the ACK-slot rise (+1 on burst reads).
// Backpressure: none toward the register port; the I2C master is only ever ACKed/NACKed, never stretched.
module i2c_slave_reg_sequencer
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       async_rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic [7:0] rx_data_out
);

   logic sda_s;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .async_rst (async_rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   state_t     state_q;
   logic [3:0] bit_cnt_q;
   logic [6:0] rx_sh_q;
   logic [7:0] tx_sh_q;
   logic       rw_q;
   logic       re_pend_q;
   logic       rd_lat_q;
   logic       sda_oe_q;
   logic       busy_q;
   logic       reg_we_q;
   logic       reg_re_q;
   logic [7:0] reg_addr_q;
   logic [7:0] reg_wdata_q;
   logic [7:0] rx_data_q;

   // Byte as it stands once the bit on the current rise is shifted in.
   logic [7:0] byte_d;
   logic       last_bit;
   assign byte_d   = {rx_sh_q, sda_s};
   assign last_bit = (bit_cnt_q == 4'd7);

   // Transaction FSM: bit sampling on SCL rise, SDA changes on SCL fall.
   always_ff @(posedge clk or negedge async_rst) begin
      if (!async_rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         rx_sh_q     <= 7'd0;
         tx_sh_q     <= 8'd0;
         rw_q        <= RW_WRITE;
         re_pend_q   <= 1'b0;
         rd_lat_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         reg_addr_q  <= 8'd0;
         reg_wdata_q <= 8'd0;
         rx_data_q   <= 8'd0;
      end else begin
         // Strobes are single-cycle; a burst read fires reg_re one cycle after the pointer bump.
         reg_we_q  <= 1'b0;
         reg_re_q  <= re_pend_q;
         re_pend_q <= 1'b0;
         // Read data arrives the cycle after reg_re; capture it for the next byte out.
         rd_lat_q  <= reg_re_q;
         if (rd_lat_q) begin
            tx_sh_q <= reg_rdata;
         end
         // Writes use the pointer during the strobe, then advance it.
         if (reg_we_q) begin
            reg_addr_q <= reg_addr_q + 8'd1;
         end

         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else if (stop_det) begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_ADDR: begin
                  if (scl_rise) begin
                     rx_sh_q   <= byte_d[6:0];
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (last_bit) begin
                        if (byte_d[7:1] == SLAVE_ADDR) begin
                           state_q <= ST_ADDR_ACK;
                           rw_q    <= byte_d[0];
                           busy_q  <= 1'b1;
                        end else begin
                           state_q <= ST_WAIT_STOP;
                        end
                     end
                  end
               end

               // First fall opens the ACK slot (drive low), second fall closes it.
               ST_ADDR_ACK: begin
                  if (scl_rise && (rw_q == RW_READ)) begin
                     reg_re_q <= 1'b1;
                  end
                  if (scl_fall) begin
                     if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                     end else if (rw_q == RW_WRITE) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= ST_PTR;
                     end else begin
                        sda_oe_q  <= ~tx_sh_q[7];
                        tx_sh_q   <= {tx_sh_q[6:0], 1'b1};
                        bit_cnt_q <= 4'd0;
                        state_q   <= ST_RD;
                     end
                  end
               end

               ST_PTR, ST_WR: begin
                  if (scl_rise) begin
                     rx_sh_q   <= byte_d[6:0];
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (last_bit) begin
                        if (state_q == ST_PTR) begin
                           reg_addr_q <= byte_d;
                           state_q    <= ST_PTR_ACK;
                        end else begin
                           reg_wdata_q <= byte_d;
                           rx_data_q   <= byte_d;
                           reg_we_q    <= 1'b1;
                           state_q     <= ST_WR_ACK;
                        end
                     end
                  end
               end

               ST_PTR_ACK, ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= ST_WR;
                     end
                  end
               end

               // MSB already on the wire when entering; each fall shifts the next bit out.
               ST_RD: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
                  if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_RD_ACK;
                     end else begin
                        sda_oe_q <= ~tx_sh_q[7];
                        tx_sh_q  <= {tx_sh_q[6:0], 1'b1};
                     end
                  end
               end

               // Master ACK fetches the next byte; NACK ends the read.
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s == NACK) begin
                        state_q <= ST_WAIT_STOP;
                        busy_q  <= 1'b0;
                     end else begin
                        reg_addr_q <= reg_addr_q + 8'd1;
                        re_pend_q  <= 1'b1;
                     end
                  end
                  if (scl_fall) begin
                     sda_oe_q  <= ~tx_sh_q[7];
                     tx_sh_q   <= {tx_sh_q[6:0], 1'b1};
                     bit_cnt_q <= 4'd0;
                     state_q   <= ST_RD;
                  end
               end

               ST_IDLE, ST_WAIT_STOP: begin
                  sda_oe_q <= 1'b0;
               end

               default: begin
                  state_q  <= ST_IDLE;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda_oe      = sda_oe_q;
   assign busy        = busy_q;
   assign reg_addr    = reg_addr_q;
   assign reg_wdata   = reg_wdata_q;
   assign reg_we      = reg_we_q;
   assign reg_re      = reg_re_q;
   assign rx_data_out = rx_data_q;

endmodule

// File: tb/tb_i2c_slave_reg_sequencer.sv
// Bus-level bench: bit-banged I2C master, register file behind the slave, scoreboard on strobes.
// Model works at transaction level: a pointer, a byte array and queues of expected strobes.
// Summary line reports total comparisons and failures.
module tb_i2c_slave_reg_sequencer;

   localparam int         Q     = 6;       // clk cycles per quarter SCL period
   localparam logic [6:0] ADDR7 = 7'h53;

   logic       clk       = 1'b0;
   logic       async_rst = 1'b0;
   logic       scl_in    = 1'b1;
   logic       sda_m     = 1'b1;
   logic       sda_oe;
   logic       busy;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] rx_data_out;
   logic [7:0] reg_rdata = 8'h00;
   wire        sda_line  = sda_m & ~sda_oe;

   int checks = 0;
   int errors = 0;

   // Register file sitting behind the slave's register port.
   logic [7:0] regfile [256] = '{default: 8'h00};

   // Reference model state.
   logic [7:0]  ref_mem [256] = '{default: 8'h00};
   logic [7:0]  ref_ptr = 8'h00;
   logic [7:0]  ref_rx  = 8'h00;
   logic [15:0] exp_wr_q [$];
   logic [7:0]  exp_rd_q [$];
   logic [7:0]  wdat [8];
   logic        busy_seen = 1'b0;
   logic        oe_seen   = 1'b0;
   logic        oe_prev   = 1'b0;

   always #5 clk = ~clk;

   i2c_slave_reg_sequencer #(
      .SLAVE_ADDR  (ADDR7),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .async_rst   (async_rst),
      .scl_in      (scl_in),
      .sda_in      (sda_line),
      .sda_oe      (sda_oe),
      .busy        (busy),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_we      (reg_we),
      .reg_re      (reg_re),
      .reg_rdata   (reg_rdata),
      .rx_data_out (rx_data_out)
   );

   always @(posedge clk) begin
      if (reg_we) regfile[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= regfile[reg_addr];
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected strobes as the DUT presents them; watches SDA discipline.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (reg_we) begin
            if (exp_wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_reg_we: addr 0x%0h data 0x%0h, expected no write", reg_addr, reg_wdata);
            end else begin
               e = exp_wr_q.pop_front();
               check("reg_we_addr", {8'h00, reg_addr}, {8'h00, e[15:8]});
               check("reg_we_data", {8'h00, reg_wdata}, {8'h00, e[7:0]});
            end
         end
         if (reg_re) begin
            if (exp_rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_reg_re: addr 0x%0h, expected no read", reg_addr);
            end else begin
               e = {8'h00, exp_rd_q.pop_front()};
               check("reg_re_addr", {8'h00, reg_addr}, e);
            end
         end
         if (async_rst && scl_in && (sda_oe !== oe_prev)) begin
            checks++; errors++;
            $display("FAIL sda_oe_during_scl_high: actual %0b, expected unchanged %0b", sda_oe, oe_prev);
         end
         oe_prev = sda_oe;
         if (busy) busy_seen = 1'b1;
         if (sda_oe) oe_seen = 1'b1;
      end
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_clks(Q);
      scl_in = 1'b1; wait_clks(Q);
      sda_m = 1'b0; wait_clks(Q);
      scl_in = 1'b0; wait_clks(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clks(Q);
      scl_in = 1'b1; wait_clks(Q);
      sda_m = 1'b1; wait_clks(2 * Q);
   endtask

   // One SCL period: master puts b on SDA, returns the wired-AND level mid-high.
   task automatic clock_bit(input logic b, output logic seen);
      sda_m = b; wait_clks(Q);
      scl_in = 1'b1; wait_clks(Q);
      seen = sda_line; wait_clks(Q);
      scl_in = 1'b0; wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack_bit);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack_bit);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         b[i] = s;
      end
      clock_bit(mack, s);
   endtask

   task automatic txn_write(input logic [7:0] ptr, input int n);
      logic a;
      bus_start();
      write_byte({ADDR7, 1'b0}, a);
      check("addr_ack_w", {15'd0, a}, 16'd0);
      check("busy_after_match", {15'd0, busy}, 16'd1);
      write_byte(ptr, a);
      check("ptr_ack", {15'd0, a}, 16'd0);
      ref_ptr = ptr;
      for (int i = 0; i < n; i++) begin
         exp_wr_q.push_back({ref_ptr, wdat[i]});
         ref_mem[ref_ptr] = wdat[i];
         ref_rx = wdat[i];
         write_byte(wdat[i], a);
         check("data_ack", {15'd0, a}, 16'd0);
         ref_ptr = ref_ptr + 8'd1;
      end
      bus_stop();
      check("rx_data_out", {8'h00, rx_data_out}, {8'h00, ref_rx});
      check("reg_addr_after_write", {8'h00, reg_addr}, {8'h00, ref_ptr});
      check("busy_after_stop", {15'd0, busy}, 16'd0);
      check("sda_released_after_write", {15'd0, sda_oe}, 16'd0);
   endtask

   task automatic txn_read(input logic set_ptr, input logic [7:0] ptr, input int n);
      logic       a;
      logic [7:0] b;
      bus_start();
      if (set_ptr) begin
         write_byte({ADDR7, 1'b0}, a);
         check("addr_ack_w", {15'd0, a}, 16'd0);
         write_byte(ptr, a);
         check("ptr_ack", {15'd0, a}, 16'd0);
         ref_ptr = ptr;
         bus_start();
      end
      for (int i = 0; i < n; i++) exp_rd_q.push_back(8'(ref_ptr + 8'(i)));
      write_byte({ADDR7, 1'b1}, a);
      check("addr_ack_r", {15'd0, a}, 16'd0);
      for (int i = 0; i < n; i++) begin
         read_byte((i == n - 1), b);
         check("read_data", {8'h00, b}, {8'h00, ref_mem[ref_ptr]});
         if (i < n - 1) ref_ptr = ref_ptr + 8'd1;
      end
      check("sda_released_after_nack", {15'd0, sda_oe}, 16'd0);
      check("busy_after_nack", {15'd0, busy}, 16'd0);
      bus_stop();
      check("reg_addr_after_read", {8'h00, reg_addr}, {8'h00, ref_ptr});
   endtask

   initial begin
      logic       a;
      logic       s;
      logic [7:0] keep_addr;

      // Reset state
      wait_clks(4);
      check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_reg_we", {15'd0, reg_we}, 16'd0);
      check("rst_reg_re", {15'd0, reg_re}, 16'd0);
      check("rst_reg_addr", {8'h00, reg_addr}, 16'h0000);
      check("rst_reg_wdata", {8'h00, reg_wdata}, 16'h0000);
      check("rst_rx_data", {8'h00, rx_data_out}, 16'h0000);
      async_rst = 1'b1;
      wait_clks(4);

      // Single write
      wdat[0] = 8'h55;
      txn_write(8'h10, 1);

      // Burst wrapping through 0xFF
      wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
      txn_write(8'hFE, 3);

      // Load read data, then pointer write + repeated-start read of two bytes
      wdat[0] = 8'h3C; wdat[1] = 8'hB3;
      txn_write(8'h20, 2);
      txn_read(1'b1, 8'h20, 2);

      // Address mismatch: no ACK, no strobes, never busy
      keep_addr = reg_addr;
      busy_seen = 1'b0;
      oe_seen   = 1'b0;
      bus_start();
      write_byte(8'hA4, a);
      check("mismatch_nack", {15'd0, a}, 16'd1);
      write_byte(8'h10, a);
      check("mismatch_data_nack", {15'd0, a}, 16'd1);
      bus_stop();
      check("mismatch_busy_seen", {15'd0, busy_seen}, 16'd0);
      check("mismatch_oe_seen", {15'd0, oe_seen}, 16'd0);
      check("mismatch_reg_addr", {8'h00, reg_addr}, {8'h00, keep_addr});

      // STOP in the middle of a data byte
      bus_start();
      write_byte({ADDR7, 1'b0}, a);
      check("abort_addr_ack", {15'd0, a}, 16'd0);
      write_byte(8'h30, a);
      check("abort_ptr_ack", {15'd0, a}, 16'd0);
      ref_ptr = 8'h30;
      for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
      bus_stop();
      check("abort_reg_addr", {8'h00, reg_addr}, 16'h0030);
      check("abort_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_rx_data", {8'h00, rx_data_out}, {8'h00, ref_rx});

      // Reset while the slave is pulling SDA low for a 0 data bit
      wdat[0] = 8'h00;
      txn_write(8'h40, 1);
      bus_start();
      write_byte({ADDR7, 1'b0}, a);
      write_byte(8'h40, a);
      ref_ptr = 8'h40;
      bus_start();
      exp_rd_q.push_back(8'h40);
      write_byte({ADDR7, 1'b1}, a);
      check("rstmid_addr_ack", {15'd0, a}, 16'd0);
      clock_bit(1'b1, s);
      check("rstmid_bit7", {15'd0, s}, 16'd0);
      clock_bit(1'b1, s);
      check("rstmid_bit6", {15'd0, s}, 16'd0);
      check("rstmid_driving", {15'd0, sda_oe}, 16'd1);
      #3 async_rst = 1'b0;
      #1;
      check("rstmid_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("rstmid_busy", {15'd0, busy}, 16'd0);
      check("rstmid_reg_addr", {8'h00, reg_addr}, 16'h0000);
      check("rstmid_reg_wdata", {8'h00, reg_wdata}, 16'h0000);
      check("rstmid_rx_data", {8'h00, rx_data_out}, 16'h0000);
      check("rstmid_strobes", {14'd0, reg_we, reg_re}, 16'd0);
      ref_ptr = 8'h00;
      ref_rx  = 8'h00;
      wait_clks(3);
      async_rst = 1'b1;
      wait_clks(4);
      wdat[0] = 8'hC7; wdat[1] = 8'h18;
      txn_write(8'h81, 2);
      txn_read(1'b1, 8'h81, 2);

      // Randomized transactions against the model
      for (int t = 0; t < 12; t++) begin
         int op;
         int n;
         op = $urandom_range(0, 2);
         if (op == 0) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
            txn_write(8'($urandom), n);
         end else begin
            n = $urandom_range(1, 3);
            txn_read((op == 1), 8'($urandom), n);
         end
      end

      wait_clks(8);
      check("wr_queue_empty", 16'(exp_wr_q.size()), 16'd0);
      check("rd_queue_empty", 16'(exp_rd_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_reg_sequencer.md
Name: i2c_slave_reg_sequencer

Overview:
System-clocked I2C slave transaction controller. Oversamples raw SCL/SDA, detects START/STOP, matches the 7-bit slave address and sequences byte transfers against a register-file port. The first written byte is the register pointer; later bytes are written or read at the pointer, with auto-increment. It sits between the SCL/SDA pads (open-drain, SDA only) and the design's register space, replacing the SCL-clocked control path with a single-clock one.

Parameters:
SLAVE_ADDR, 7'h53, 7-bit address the block responds to
SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2)

Ports:
clk  in  1  system clock, must run at least 8x the SCL frequency
async_rst  in  1  asynchronous active-low reset
scl_in  in  1  raw SCL pad input
sda_in  in  1  raw SDA pad input
sda_oe  out  1  1 = pull SDA low; pad drives 0 when set, else Z
busy  out  1  high from address match until STOP/START/NACK exit
reg_addr  out  8  register pointer
reg_wdata  out  8  write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid the cycle after reg_re
rx_data_out  out  8  last received data byte, excluding the address and pointer bytes

Behaviour:
- Reset (async_rst=0): state IDLE; sda_oe, busy, reg_we, reg_re = 0; reg_addr, reg_wdata, rx_data_out = 0; synchronizers = 1.
- Reset mid-transfer releases SDA immediately (asynchronous).
- Sync: scl_s/sda_s after SYNC_STAGES flops. rise/fall = scl_s vs its previous value.
- START: sda_s falls while scl_s=1. STOP: sda_s rises while scl_s=1.
- Data is sampled on the scl rise cycle. sda_oe changes only on scl fall cycles, except on START/STOP.
- Bit counter 0..8 per byte. Bit 8 is the ACK slot.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
- START from any state: goes to ADDR, counter=0, sda_oe=0 next cycle. This covers repeated START.
- STOP from any state: goes to IDLE, sda_oe=0, busy=0 next cycle.
- ADDR: shift 8 bits, MSB first.
  - On the 8th rise, compare [7:1] with SLAVE_ADDR.
  - Match: go to ADDR_ACK and assert sda_oe at the next fall.
  - Mismatch: go to WAIT_STOP (NACK, sda_oe stays 0).
- ADDR_ACK: release SDA at the fall ending the ACK slot.
  - If R/W=0, go to PTR.
  - If R/W=1: pulse reg_re on the ACK-slot rise, latch reg_rdata the next cycle, drive MSB at the ACK-ending fall, then go to RD.
- PTR: on the 8th rise, load reg_addr and go to PTR_ACK (ACK), then WR.
- WR: on the 8th rise, reg_wdata = rx_data_out = byte; reg_we pulses that cycle with the current reg_addr; reg_addr increments the next cycle. Then WR_ACK (ACK), then WR.
- RD: each fall drives sda_oe = ~tx_bit (0-bits pull low). SDA is released at the fall after bit 0, then go to RD_ACK.
- RD_ACK: sample master ACK on the rise.
  - ACK (0): reg_addr+1, pulse reg_re one cycle after the increment, latch data, drive next MSB at the following fall, go to RD.
  - NACK: go to WAIT_STOP.
- reg_addr wraps 8'hFF to 8'h00.
- The pointer persists across transactions, so a read without a pointer write uses the last pointer.
- WAIT_STOP: SDA released; only START or STOP exits.
- The slave never drives SDA during the SCL-high phase. START and STOP on the same cycle are impossible because only one sda_s edge occurs per cycle.

Decomposition:
- Package i2c_slave_pkg: state enum, ACK=1'b0 / NACK=1'b1, RW_WRITE=0 / RW_READ=1, SLAVE_ADDR default.
- Sub-module i2c_sync_edge: synchronizers, scl rise/fall, start/stop pulses.

Test Plan:
- Write: START, 0xA6, 0x10, 0x55, STOP -> three ACKs; reg_we once with reg_addr=0x10, reg_wdata=0x55; rx_data_out=0x55; final reg_addr=0x11.
- Burst wrap: pointer 0xFE, data 0x01, 0x02, 0x03 -> writes at 0xFE, 0xFF, 0x00; final reg_addr=0x01.
- Repeated-start read: START, 0xA6, 0x20, Sr, 0xA7, read 2 bytes (ACK, then NACK) with rdata 0x3C then 0xB3 -> SDA carries 0x3C, 0xB3; two reg_re pulses at 0x20 and 0x21; SDA released after the NACK.
- Address mismatch: START, 0xA4, 0x10, STOP -> NACK, no reg_we/reg_re, busy stays 0, sda_oe never 1.
- STOP after 4 bits of a data byte -> IDLE, no reg_we, sda_oe=0.
- async_rst low while driving a 0 data bit -> sda_oe=0 immediately; all outputs at reset values; next transaction works normally.
